// File: rtl/fft_ctrl_param.sv
// fft_ctrl_param: control FSM for an in-place radix-2 DIF FFT of N = 2^LOG2N points.
// Collects a frame, sequences every butterfly stage, then streams the bit-reversed result.
module fft_ctrl_param #(
   parameter int LOG2N  = 4,
   parameter int DW     = 16,
   parameter int BF_LAT = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_push,
   input  logic [DW-1:0]      in_real,
   input  logic [DW-1:0]      in_imag,
   output logic               in_stall_F,
   output logic [LOG2N-1:0]   read_addr_1_F,
   output logic [LOG2N-1:0]   read_addr_2_F,
   output logic [LOG2N-2:0]   W_addr_F,
   output logic [LOG2N-1:0]   write_addr_1_F,
   output logic [LOG2N-1:0]   write_addr_2_F,
   output logic [2*DW-1:0]    write_data_1_F,
   output logic               write_en_1_F,
   output logic               write_en_2_F,
   output logic               write_back_F,
   output logic               out_push_F,
   input  logic               out_stall,
   output logic               frame_done_F
);
   localparam int N  = 1 << LOG2N;
   localparam int SW = $clog2(LOG2N + 1);
   localparam int LW = $clog2(BF_LAT + 1);
   localparam int EW = 2 * LOG2N + 1;
   localparam logic [LOG2N-1:0] ONE    = LOG2N'(1);
   localparam logic [LOG2N-1:0] LAST   = LOG2N'(N - 1);
   localparam logic [LOG2N-2:0] LAST_B = '1;
   localparam logic [SW-1:0]    LAST_S = SW'(LOG2N - 1);
   localparam logic [LW-1:0]    LAST_L = LW'(BF_LAT - 1);

   typedef enum logic [1:0] {RX, CALC, BUBBLE, TX} state_t;

   state_t                    state_q, state_d;
   logic [LOG2N-1:0]          cnt_q, cnt_d;
   logic [SW-1:0]             stage_q, stage_d;
   logic [LOG2N-2:0]          bfly_q, bfly_d;
   logic [LW-1:0]             lat_q, lat_d;
   logic [BF_LAT-1:0][EW-1:0] dl_q, dl_d;
   logic                      in_stall_q, in_stall_d;
   logic [LOG2N-1:0]          ra1_q, ra1_d, ra2_q, ra2_d;
   logic [LOG2N-2:0]          w_q, w_d;
   logic [LOG2N-1:0]          wa1_q, wa1_d, wa2_q, wa2_d;
   logic [2*DW-1:0]           wd_q, wd_d;
   logic                      we1_q, we1_d, we2_q, we2_d, wb_q, wb_d;
   logic                      op_q, op_d, fd_q, fd_d;
   logic [LOG2N-1:0]          be, msk, a_c, b_c, w_full, rev;

   // msk = span-1; A keeps the low bits of b and opens a zero gap at the span bit
   always_comb begin
      be = {1'b0, bfly_q};
      msk = {LOG2N{1'b1}} >> (stage_q + SW'(1));
      a_c = ((be & ~msk) << 1) | (be & msk);
      b_c = a_c + msk + ONE;
      w_full = (be & msk) << stage_q;
      rev = '0;
      for (int i = 0; i < LOG2N; i++) rev[i] = cnt_q[LOG2N-1-i];
      state_d = state_q; cnt_d = cnt_q; stage_d = stage_q; bfly_d = bfly_q; lat_d = lat_q;
      in_stall_d = in_stall_q; ra1_d = ra1_q; ra2_d = ra2_q; w_d = w_q;
      wa1_d = wa1_q; wa2_d = wa2_q; wd_d = wd_q; wb_d = wb_q;
      we1_d = 1'b0; we2_d = 1'b0; op_d = 1'b0; fd_d = 1'b0;
      dl_d[0] = '0;
      for (int i = 1; i < BF_LAT; i++) dl_d[i] = dl_q[i-1];
      case (state_q)
         RX: begin
            in_stall_d = 1'b0;
            if (in_push && !in_stall_q) begin
               wa1_d = cnt_q; wd_d = {in_real, in_imag}; we1_d = 1'b1; wb_d = 1'b0;
               cnt_d = cnt_q + ONE;
               if (cnt_q == LAST) begin
                  in_stall_d = 1'b1; cnt_d = '0; stage_d = '0; bfly_d = '0; state_d = CALC;
               end
            end
         end
         CALC: begin
            ra1_d = a_c; ra2_d = b_c; w_d = w_full[LOG2N-2:0];
            dl_d[0] = {1'b1, a_c, b_c};
            bfly_d = bfly_q + (LOG2N-1)'(1);
            if (bfly_q == LAST_B) begin
               lat_d = '0; state_d = BUBBLE;
            end
         end
         BUBBLE: begin
            lat_d = lat_q + LW'(1);
            if (lat_q == LAST_L) begin
               lat_d = '0; stage_d = stage_q + SW'(1); state_d = CALC;
               if (stage_q == LAST_S) begin
                  stage_d = '0; cnt_d = '0; state_d = TX;
               end
            end
         end
         TX: begin
            if (!out_stall) begin
               op_d = 1'b1; ra1_d = rev; ra2_d = '0; cnt_d = cnt_q + ONE;
               if (cnt_q == LAST) begin
                  fd_d = 1'b1; cnt_d = '0; state_d = RX;
               end
            end
         end
         default: state_d = RX;
      endcase
      if (dl_q[BF_LAT-1][EW-1]) begin
         wa1_d = dl_q[BF_LAT-1][EW-2:LOG2N]; wa2_d = dl_q[BF_LAT-1][LOG2N-1:0];
         we1_d = 1'b1; we2_d = 1'b1; wb_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RX; cnt_q <= '0; stage_q <= '0; bfly_q <= '0; lat_q <= '0; dl_q <= '0;
         in_stall_q <= 1'b1; ra1_q <= '0; ra2_q <= '0; w_q <= '0;
         wa1_q <= '0; wa2_q <= '0; wd_q <= '0; we1_q <= 1'b0; we2_q <= 1'b0; wb_q <= 1'b0;
         op_q <= 1'b0; fd_q <= 1'b0;
      end else begin
         state_q <= state_d; cnt_q <= cnt_d; stage_q <= stage_d; bfly_q <= bfly_d; lat_q <= lat_d;
         dl_q <= dl_d; in_stall_q <= in_stall_d; ra1_q <= ra1_d; ra2_q <= ra2_d; w_q <= w_d;
         wa1_q <= wa1_d; wa2_q <= wa2_d; wd_q <= wd_d; we1_q <= we1_d; we2_q <= we2_d; wb_q <= wb_d;
         op_q <= op_d; fd_q <= fd_d;
      end
   end

   assign in_stall_F     = in_stall_q;
   assign read_addr_1_F  = ra1_q;
   assign read_addr_2_F  = ra2_q;
   assign W_addr_F       = w_q;
   assign write_addr_1_F = wa1_q;
   assign write_addr_2_F = wa2_q;
   assign write_data_1_F = wd_q;
   assign write_en_1_F   = we1_q;
   assign write_en_2_F   = we2_q;
   assign write_back_F   = wb_q;
   assign out_push_F     = op_q;
   assign frame_done_F   = fd_q;
endmodule

// File: tb/tb_fft_ctrl_param.sv
// tb_fft_ctrl_param: directed bench for fft_ctrl_param at the defaults and at LOG2N=3, BF_LAT=2.
module tb_fft_ctrl_param;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        reset, in_push, out_stall, in_stall_F;
   logic [15:0] in_real, in_imag;
   logic [3:0]  ra1, ra2, wa1, wa2;
   logic [2:0]  wadr;
   logic [31:0] wd;
   logic        we1, we2, wb, op, fd;

   logic        s_reset, s_in_push, s_out_stall, s_in_stall;
   logic [15:0] s_in_real, s_in_imag;
   logic [2:0]  s_ra1, s_ra2, s_wa1, s_wa2;
   logic [1:0]  s_wadr;
   logic [31:0] s_wd;
   logic        s_we1, s_we2, s_wb, s_op, s_fd;

   logic [3:0] rev16 [16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                              4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};
   logic [2:0] rev8 [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

   int n_wr, n_bad, pushes, n_fd;

   fft_ctrl_param dut (
      .clk(clk), .reset(reset), .in_push(in_push), .in_real(in_real), .in_imag(in_imag),
      .in_stall_F(in_stall_F), .read_addr_1_F(ra1), .read_addr_2_F(ra2), .W_addr_F(wadr),
      .write_addr_1_F(wa1), .write_addr_2_F(wa2), .write_data_1_F(wd),
      .write_en_1_F(we1), .write_en_2_F(we2), .write_back_F(wb),
      .out_push_F(op), .out_stall(out_stall), .frame_done_F(fd)
   );

   fft_ctrl_param #(.LOG2N(3), .DW(16), .BF_LAT(2)) dut2 (
      .clk(clk), .reset(s_reset), .in_push(s_in_push), .in_real(s_in_real), .in_imag(s_in_imag),
      .in_stall_F(s_in_stall), .read_addr_1_F(s_ra1), .read_addr_2_F(s_ra2), .W_addr_F(s_wadr),
      .write_addr_1_F(s_wa1), .write_addr_2_F(s_wa2), .write_data_1_F(s_wd),
      .write_en_1_F(s_we1), .write_en_2_F(s_we2), .write_back_F(s_wb),
      .out_push_F(s_op), .out_stall(s_out_stall), .frame_done_F(s_fd)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1; in_push = 0; in_real = 0; in_imag = 0; out_stall = 0;
      s_reset = 1; s_in_push = 0; s_in_real = 0; s_in_imag = 0; s_out_stall = 0;
      repeat (3) tick();
      chk("rst_in_stall", in_stall_F, 1);
      chk("rst_we1", we1, 0);
      chk("rst_we2", we2, 0);
      chk("rst_out_push", op, 0);
      chk("rst_frame_done", fd, 0);
      chk("rst_ra1", ra1, 0);
      chk("rst_wa1", wa1, 0);
      chk("rst_wd", wd, 0);

      // push offered while in_stall_F is still high must be dropped
      reset = 0; in_push = 1; in_real = 16'hdead; in_imag = 16'hbeef;
      tick();
      chk("release_in_stall", in_stall_F, 0);
      chk("ignored_push", we1, 0);

      for (int k = 0; k < 16; k++) begin
         if (k == 5) begin
            in_push = 0; in_real = 16'h5555;
            tick();
            chk("gap_no_write", we1, 0);
         end
         in_push = 1; in_real = 16'(k); in_imag = 16'(16'h00a0 + k);
         tick();
         chk("rx_we", we1, 1);
         chk("rx_addr", wa1, k);
         chk("rx_data", wd, {16'(k), 16'(16'h00a0 + k)});
         chk("rx_wb", wb, 0);
         chk("rx_in_stall", in_stall_F, k == 15);
      end

      // CALC, BUBBLE and TX of frame 1; pushes during CALC must be ignored
      in_real = 16'h7777;
      n_wr = 0; n_bad = 0; pushes = 0; n_fd = 0;
      for (int e = 1; e <= 70; e++) begin
         tick();
         if (we1) begin
            n_wr++;
            if (!wb || op || !we2) n_bad++;
         end
         if (fd) n_fd++;
         if (op) begin
            if (pushes < 16) chk("tx_order", ra1, rev16[pushes]);
            chk("tx_done", fd, pushes == 15);
            pushes++;
         end
         case (e)
            1: begin chk("s0b0_A", ra1, 0); chk("s0b0_B", ra2, 8); chk("s0b0_W", wadr, 0); end
            4: chk("no_early_write", we1, 0);
            5: begin chk("s0b0_wr_A", wa1, 0); chk("s0b0_wr_B", wa2, 8); chk("s0b0_we2", we2, 1); end
            12: begin chk("s0b7_wr_A", wa1, 7); chk("s0b7_wr_B", wa2, 15); end
            13: begin chk("s1b0_A", ra1, 0); chk("s1b0_B", ra2, 4); chk("s1b0_no_we", we1, 0); end
            18: begin chk("s1b5_A", ra1, 9); chk("s1b5_B", ra2, 13); chk("s1b5_W", wadr, 2); end
            40: begin chk("s3b3_A", ra1, 6); chk("s3b3_B", ra2, 7); chk("s3b3_W", wadr, 0); end
            48: begin chk("last_wr", we1, 1); chk("last_wr_A", wa1, 14); chk("last_wr_B", wa2, 15);
                      chk("no_push_yet", op, 0); end
            49: chk("first_push", op, 1);
            52: begin chk("stalled_push", op, 0); chk("stalled_hold", ra1, 8); end
            68: begin chk("rx_again_in_stall", in_stall_F, 0); chk("rx_again_push", op, 0); end
            default: ;
         endcase
         out_stall = (e >= 50 && e <= 52);
         if (e >= 60) in_push = 0;
      end
      chk("write_count", n_wr, 32);
      chk("write_conflict", n_bad, 0);
      chk("push_count", pushes, 16);
      chk("frame_done_count", n_fd, 1);

      // frame 2: abort with reset while a write-back is pending
      for (int k = 0; k < 16; k++) begin
         in_push = 1; in_real = 16'(16'h0100 + k);
         tick();
      end
      in_push = 0;
      repeat (10) tick();
      reset = 1;
      tick();
      chk("abort_we_a", we1, 0);
      tick();
      chk("abort_we_b", we1, 0);
      chk("abort_in_stall", in_stall_F, 1);
      reset = 0;
      n_wr = 0;
      for (int e = 0; e < 8; e++) begin
         tick();
         if (we1 || we2) n_wr++;
         if (e == 0) chk("abort_back_to_rx", in_stall_F, 0);
      end
      chk("abort_no_writes", n_wr, 0);

      // frame 3 must run cleanly after the abort
      for (int k = 0; k < 16; k++) begin
         in_push = 1; in_real = 16'(16'h0200 + k); in_imag = 16'(k);
         tick();
         if (k == 0) chk("f3_first_addr", wa1, 0);
      end
      in_push = 0;
      pushes = 0;
      for (int e = 0; e < 120; e++) begin
         tick();
         if (op) begin
            if (pushes < 16) chk("f3_order", ra1, rev16[pushes]);
            pushes++;
         end
         if (fd) break;
      end
      chk("f3_push_count", pushes, 16);
      chk("f3_frame_done", fd, 1);

      // LOG2N=3, BF_LAT=2 instance
      s_reset = 0;
      tick();
      chk("s_release", s_in_stall, 0);
      for (int k = 0; k < 8; k++) begin
         s_in_push = 1; s_in_real = 16'(k); s_in_imag = 16'(16'h0030 + k);
         tick();
         chk("s_rx_addr", s_wa1, k);
      end
      chk("s_in_stall_after_frame", s_in_stall, 1);
      s_in_push = 0;
      pushes = 0; n_fd = 0;
      for (int e = 1; e <= 30; e++) begin
         tick();
         if (s_fd) n_fd++;
         if (s_op) begin
            if (pushes < 8) chk("s_tx_order", s_ra1, rev8[pushes]);
            chk("s_tx_done", s_fd, pushes == 7);
            pushes++;
         end
         case (e)
            9: begin chk("s_s1b2_A", s_ra1, 4); chk("s_s1b2_B", s_ra2, 6); chk("s_s1b2_W", s_wadr, 0); end
            11: begin chk("s_s1b2_wr_A", s_wa1, 4); chk("s_s1b2_wr_B", s_wa2, 6); end
            18: begin chk("s_last_wr", s_we1, 1); chk("s_last_wr_A", s_wa1, 6); chk("s_no_push_yet", s_op, 0); end
            19: chk("s_first_push", s_op, 1);
            default: ;
         endcase
      end
      chk("s_push_count", pushes, 8);
      chk("s_frame_done_count", n_fd, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fft_ctrl_param.md
# fft_ctrl_param

Parametrised control state machine for the in-place radix-2 decimation-in-frequency FFT, for N = 2^LOG2N points. It sits between the input stream, the dual-port sample memory, the butterfly datapath and the output stream. It collects one frame of N complex samples and sequences all LOG2N butterfly stages with a configurable butterfly read-to-write latency. It then streams the bit-reversed result under downstream backpressure. All butterfly addresses and twiddle indices are generated arithmetically, with no lookup table.

## Interface
- LOG2N, 4, log2 of points per frame (N = 2^LOG2N, LOG2N ≥ 2)
- DW, 16, width of each of the real and imaginary components
- BF_LAT, 4, cycles from read_addr_*_F valid to the matching write_en_*_F (≥ 1)
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- in_push  in  1  input sample valid
- in_real, in_imag  in  DW each  input sample components
- in_stall_F  out  1  registered hold to the sender; a push is accepted only when in_stall_F=0 and in_push=1
- read_addr_1_F, read_addr_2_F  out  LOG2N  memory read addresses (butterfly A/B; output address on port 1)
- W_addr_F  out  LOG2N-1  twiddle index for the butterfly currently being read
- write_addr_1_F, write_addr_2_F  out  LOG2N  memory write addresses
- write_data_1_F  out  2*DW  {in_real, in_imag} of the accepted sample
- write_en_1_F, write_en_2_F  out  1  memory write enables
- write_back_F  out  1  selects butterfly results (1) rather than write_data_1_F (0) as the write source
- out_push_F  out  1  output valid; coincides with read_addr_1_F carrying the output address
- out_stall  in  1  downstream hold, sampled in the same cycle it is applied
- frame_done_F  out  1  one-cycle pulse with the last out_push_F of a frame

## Operation
- All outputs are registered (next-value logic → flop).
- Reset values: in_stall_F=1. All other outputs are 0. State=RX; counter, stage and butterfly are 0; the write-address delay line is cleared and invalid.
- Reset asserted in any state aborts the frame. Nothing partial is flushed and no write occurs after reset.
- **RX**
  - in_stall_F is driven 0.
  - On each accept: write_addr_1_F=counter, write_data_1_F={in_real,in_imag}, write_en_1_F=1, write_back_F=0, counter+1.
  - Gaps in in_push are tolerated; the counter holds.
  - On the accept with counter=N-1: in_stall driven 1, counter and stage/butterfly cleared, go to CALC.
  - A push while in_stall_F=1 is ignored.
- **CALC**, per stage s=0..LOG2N-1 and butterfly b=0..N/2-1, with span=2^(LOG2N-1-s):
  - A = ((b >> (LOG2N-1-s)) << (LOG2N-s)) | (b & (span-1))
  - B = A + span
  - W = (b & (span-1)) << s
  - One butterfly is issued per cycle: read_addr_1_F=A, read_addr_2_F=B, W_addr_F=W.
  - After b=N/2-1 of a stage, enter BUBBLE for exactly BF_LAT cycles before stage s+1 issues. This covers the read-after-write hazard.
- **Write-back:** A/B and a valid bit travel down a BF_LAT-deep delay line. When the valid bit emerges: write_addr_1_F=A, write_addr_2_F=B, write_en_1_F=write_en_2_F=write_back_F=1.
- **Stage completion:** after the BUBBLE of stage LOG2N-1, all writes are complete; go to TX with counter=0.
- **TX**
  - If out_stall=0: out_push_F=1, read_addr_1_F=bitrev(counter), read_addr_2_F=0, counter+1.
  - If out_stall=1: out_push_F=0, counter holds, and the addresses hold their last value.
  - On the push with counter=N-1: frame_done_F=1 and go to RX. in_stall_F drops in the next cycle.
- Counters are LOG2N bits wide and wrap to 0 on the transition out of each state.

## Timing
- First accept is possible 2 cycles after reset deasserts (in_stall_F falls 1 cycle after reset).
- in_stall_F rises in the cycle after the N-th accept.
- First CALC read is in the cycle after the N-th write_en_1_F.
- Butterfly read at cycle c → its write at cycle c+BF_LAT.
- CALC+BUBBLE length is LOG2N*(N/2+BF_LAT) cycles; for defaults, 48.
- TX length is N cycles plus the number of stalled cycles.
- write_en_* and out_push_F are never both high: TX starts only after the final write.

## Test plan
- Reset: hold reset 3 cycles → all outputs 0 and in_stall_F=1; in_stall_F=0 one cycle after release.
- Defaults, 16 back-to-back pushes with values 0..15 → write_addr_1_F 0..15, write_data_1_F matches input, in_stall_F=1 after the 16th accept; then stage0 b0 A=0/B=8/W=0, stage1 b5 A=9/B=13/W=2, stage3 b3 A=6/B=7/W=0; each write 4 cycles after its read; 4 idle cycles between stages.
- Pushes with gaps and pushes while in_stall_F=1 → only accepted samples are written, and the counter is unaffected by the ignored ones.
- TX with out_stall high on cycles 3–5 → read_addr_1_F sequence 0,8,4,12,2,… with no skip or repeat in out_push_F cycles; frame_done_F on the 16th push; exactly 16 pushes.
- LOG2N=3, BF_LAT=2 → CALC+BUBBLE is 18 cycles, stage1 b2 A=4/B=6/W=0, output order 0,4,2,6,1,5,3,7.
- Reset asserted mid-CALC → no write_en in the following cycles, returns to RX, and the next full frame completes normally.
